unsigned_divider_seq: RTL

Multi-cycle unsigned restoring divider, the inverse of the team's unsigned and pipelined multipliers. It takes a 2*WIDTH-bit dividend, such as a multiplier product, and a WIDTH-bit divisor. It returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder, producing one quotient bit per cycle. Operands enter and results leave through valid/ready handshakes, so the block sits directly behind a multiplier stage or a register-file read port.

---
 rtl/divider_pkg.sv | 20 ++
 rtl/divider_step.sv | 26 ++
 rtl/unsigned_divider_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential unsigned divider.
//   state_t  : FSM encoding (IDLE, CALC, DONE)
//   COUNT_W  : bit-counter width for the default WIDTH of 8
//   count_w(): the same sizing rule for any WIDTH
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int COUNT_W   = $clog2(2 * WIDTH_DEF);

    function automatic int count_w(input int w);
        return $clog2(2 * w);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step.
//   rem_in   : partial remainder (WIDTH+1 bits)
//   din      : next dividend bit, shifted in at the LSB
//   divisor  : WIDTH-bit divisor
//   rem_out  : partial remainder after the conditional subtract
//   q_bit    : quotient bit produced by this step
module divider_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] r;

    always_comb begin
        r       = {rem_in[WIDTH-1:0], din};
        // A set top bit means the shifted value already exceeds any divisor.
        q_bit   = rem_in[WIDTH] || (r >= {1'b0, divisor});
        rem_out = q_bit ? (r - {1'b0, divisor}) : r;
    end

endmodule

// File: rtl/unsigned_divider_seq.sv
// Multi-cycle unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit
// divisor -> 2*WIDTH-bit quotient and WIDTH-bit remainder, one quotient bit
// per cycle, valid/ready on both sides.
//   clk, reset_n            : clock, async active-low reset
//   in_valid/in_ready       : operand handshake (in_ready only in IDLE)
//   dividend, divisor       : operands, sampled on the accept edge
//   out_valid/out_ready     : result handshake, result held until accepted
//   quotient, remainder     : result
//   div_by_zero             : result came from a zero divisor
// Optional: define DIVIDER_EARLY_EXIT_EN to finish immediately when the
// dividend is smaller than a nonzero divisor (same results, shorter latency).
module unsigned_divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    localparam int CW = count_w(WIDTH);

    state_t             state;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so after 2*WIDTH steps this register holds the quotient.
    logic [2*WIDTH-1:0] dq;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH:0]     rem;
    logic [CW-1:0]      cnt;
    logic               dbz;
    logic               ov_q;

    logic [WIDTH:0]     rem_nxt;
    logic               q_bit;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .din     (dq[2*WIDTH-1]),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign in_ready    = (state == IDLE);
    assign out_valid   = ov_q;
    assign quotient    = dq;
    assign remainder   = rem[WIDTH-1:0];
    assign div_by_zero = dbz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            dq    <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs <= divisor;
                        cnt <= CW'(2 * WIDTH - 1);
                        dbz <= 1'b0;
                        if (divisor == '0) begin
                            dq    <= '1;
                            rem   <= {1'b0, dividend[WIDTH-1:0]};
                            dbz   <= 1'b1;
                            state <= DONE;
`ifdef DIVIDER_EARLY_EXIT_EN
                        end else if (dividend < {{WIDTH{1'b0}}, divisor}) begin
                            dq    <= '0;
                            rem   <= {1'b0, dividend[WIDTH-1:0]};
                            state <= DONE;
`endif
                        end else begin
                            dq    <= dividend;
                            rem   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    dq  <= {dq[2*WIDTH-2:0], q_bit};
                    rem <= rem_nxt;
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                DONE: begin
                    // out_valid lags entry into DONE by one cycle; the result
                    // is only released once it has actually been presented.
                    if (!ov_q) begin
                        ov_q <= 1'b1;
                    end else if (out_ready) begin
                        ov_q  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
